// File: rtl/operand_entry_fsm.sv
// ASCII operand entry front end: "DD<Enter>DD<Enter><op>" -> registered X, Y, C0 with valid/ack.
// Optional macro ECHO_EN adds ECHO_VALID/ECHO_CHAR, a one-cycle copy of every transferred byte.
module operand_entry_fsm #(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CHAR_VALID,
  input  logic [7:0]       CHAR,
  output logic             CHAR_RDY,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic             C0,
  output logic             OP_VALID,
  input  logic             OP_ACK,
  output logic             ERR
`ifdef ECHO_EN
  ,
  output logic             ECHO_VALID,
  output logic [7:0]       ECHO_CHAR
`endif
);

  typedef enum logic [3:0] {
    X_TENS, X_ONES, X_ENT,
    Y_TENS, Y_ONES, Y_ENT,
    OP, DONE, ERROR
  } state_t;

  state_t state, state_next;

  logic       xfer;
  logic       is_digit, is_enter, is_plus, is_minus;
  logic [3:0] digit_val;
  logic [3:0] tens;
  logic [6:0] acc;
  logic [6:0] acc_sum;
  logic       acc_ok;
  logic       rdy_next, valid_next, err_next;

  assign xfer      = CHAR_VALID && CHAR_RDY;
  assign is_digit  = (CHAR >= 8'h30) && (CHAR <= 8'h39);
  assign is_enter  = (CHAR == 8'h0A) || (CHAR == 8'h0D);
  assign is_plus   = (CHAR == 8'h2B);
  assign is_minus  = (CHAR == 8'h2D);
  assign digit_val = CHAR[3:0];
  assign acc_sum   = ({3'b000, tens} * 7'd10) + {3'b000, digit_val};
  assign acc_ok    = (acc <= 7'(MAX_VAL));

  // Status flags are registered alongside the state so they change on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= X_TENS;
      CHAR_RDY <= 1'b1;
      OP_VALID <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state    <= state_next;
      CHAR_RDY <= rdy_next;
      OP_VALID <= valid_next;
      ERR      <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      X_TENS: if (xfer) state_next = is_digit ? X_ONES : ERROR;
      X_ONES: if (xfer) state_next = is_digit ? X_ENT  : ERROR;
      X_ENT:  if (xfer) state_next = (is_enter && acc_ok) ? Y_TENS : ERROR;
      Y_TENS: if (xfer) state_next = is_digit ? Y_ONES : ERROR;
      Y_ONES: if (xfer) state_next = is_digit ? Y_ENT  : ERROR;
      Y_ENT:  if (xfer) state_next = (is_enter && acc_ok) ? OP : ERROR;
      OP:     if (xfer) state_next = (is_plus || is_minus) ? DONE : ERROR;
      DONE:   if (OP_ACK) state_next = X_TENS;
      ERROR:  if (xfer && is_enter) state_next = X_TENS;
      default: state_next = X_TENS;
    endcase
  end

  always_comb begin
    rdy_next   = (state_next != DONE);
    valid_next = (state_next == DONE);
    err_next   = (state_next == ERROR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tens <= '0;
      acc  <= '0;
      X    <= '0;
      Y    <= '0;
      C0   <= 1'b0;
    end else if (xfer) begin
      case (state)
        X_TENS, Y_TENS: if (is_digit) tens <= digit_val;
        X_ONES, Y_ONES: if (is_digit) acc <= acc_sum;
        X_ENT:          if (is_enter && acc_ok) X <= WIDTH'(acc);
        Y_ENT:          if (is_enter && acc_ok) Y <= WIDTH'(acc);
        OP: begin
          if (is_plus)  C0 <= 1'b0;
          if (is_minus) C0 <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ECHO_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ECHO_VALID <= 1'b0;
      ECHO_CHAR  <= '0;
    end else begin
      ECHO_VALID <= xfer;
      if (xfer) ECHO_CHAR <= CHAR;
    end
  end
`endif

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Self-checking bench for operand_entry_fsm: directed scenarios plus randomized traffic vs. a queue-based model.
module tb_operand_entry_fsm;
  localparam int WIDTH   = 5;
  localparam int MAX_VAL = 15;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             CHAR_VALID = 1'b0;
  logic [7:0]       CHAR = '0;
  logic             CHAR_RDY;
  logic [WIDTH-1:0] X, Y;
  logic             C0, OP_VALID, ERR;
  logic             OP_ACK = 1'b0;
`ifdef ECHO_EN
  logic             ECHO_VALID;
  logic [7:0]       ECHO_CHAR;
`endif

  int errors = 0;
  int checks = 0;

  // Model: bytes of the entry in progress, positions 0..6 of "DD\nDD\nop".
  logic [7:0]       q[$];
  logic [WIDTH-1:0] m_x = '0, m_y = '0;
  logic             m_c0 = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic             m_ev = 1'b0;
  logic [7:0]       m_ec = '0;

  operand_entry_fsm #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) dut (
    .CLK(CLK), .RST(RST), .CHAR_VALID(CHAR_VALID), .CHAR(CHAR), .CHAR_RDY(CHAR_RDY),
    .X(X), .Y(Y), .C0(C0), .OP_VALID(OP_VALID), .OP_ACK(OP_ACK), .ERR(ERR)
`ifdef ECHO_EN
    , .ECHO_VALID(ECHO_VALID), .ECHO_CHAR(ECHO_CHAR)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic bit is_dig(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic bit is_ent(input logic [7:0] b);
    return (b == 8'h0A) || (b == 8'h0D);
  endfunction

  task automatic model_update(input logic v, input logic [7:0] b, input logic a, input logic r);
    int n, val;
    bit bad;
    if (r) begin
      m_x = '0; m_y = '0; m_c0 = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_ev = 1'b0; m_ec = '0; q.delete();
      return;
    end
    m_ev = v && !m_done;
    if (m_ev) m_ec = b;
    if (m_done) begin
      if (a) m_done = 1'b0;
    end else if (v) begin
      if (m_err) begin
        if (is_ent(b)) m_err = 1'b0;
      end else begin
        q.push_back(b);
        n = q.size() - 1;
        bad = 1'b0;
        if (n == 0 || n == 1 || n == 3 || n == 4) begin
          bad = !is_dig(b);
        end else if (n == 2 || n == 5) begin
          val = (int'(q[n-2]) - 48) * 10 + (int'(q[n-1]) - 48);
          if (is_ent(b) && val <= MAX_VAL) begin
            if (n == 2) m_x = WIDTH'(val);
            else        m_y = WIDTH'(val);
          end else bad = 1'b1;
        end else begin
          if (b == 8'h2B || b == 8'h2D) begin
            m_c0 = (b == 8'h2D);
            m_done = 1'b1;
            q.delete();
          end else bad = 1'b1;
        end
        if (bad) begin
          m_err = 1'b1;
          q.delete();
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic a, input logic r);
    @(negedge CLK);
    CHAR_VALID = v; CHAR = b; OP_ACK = a; RST = r;
    @(posedge CLK);
    model_update(v, b, a, r);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic ack();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (X !== 5'd0 || Y !== 5'd0 || C0 !== 1'b0 || OP_VALID !== 1'b0 || ERR !== 1'b0 || CHAR_RDY !== 1'b1) begin
      errors++;
      $display("FAIL reset: X=%0d Y=%0d C0=%b OP_VALID=%b ERR=%b CHAR_RDY=%b, want 0 0 0 0 0 1", X, Y, C0, OP_VALID, ERR, CHAR_RDY);
    end
`ifdef ECHO_EN
    checks++;
    if (ECHO_VALID !== 1'b0 || ECHO_CHAR !== 8'h00) begin
      errors++;
      $display("FAIL reset_echo: ECHO_VALID=%b ECHO_CHAR=%h, want 0 00", ECHO_VALID, ECHO_CHAR);
    end
`endif
  endtask

  task automatic test_add();
    send("0"); send("7"); send(8'h0A); send("1"); send("2"); send(8'h0A);
    checks++;
    if (OP_VALID !== 1'b0) begin
      errors++; $display("FAIL add_pre_op: OP_VALID=%b want 0", OP_VALID);
    end
    send("+");
    checks++;
    if (OP_VALID !== 1'b1 || X !== 5'd7 || Y !== 5'd12 || C0 !== 1'b0 || CHAR_RDY !== 1'b0) begin
      errors++;
      $display("FAIL add_result: OP_VALID=%b X=%0d Y=%0d C0=%b RDY=%b, want 1 7 12 0 0", OP_VALID, X, Y, C0, CHAR_RDY);
    end
    idle(); idle();
    checks++;
    if (CHAR_RDY !== 1'b0 || OP_VALID !== 1'b1) begin
      errors++; $display("FAIL add_hold: RDY=%b OP_VALID=%b, want 0 1", CHAR_RDY, OP_VALID);
    end
    ack();
    checks++;
    if (CHAR_RDY !== 1'b1 || OP_VALID !== 1'b0) begin
      errors++; $display("FAIL add_ack: RDY=%b OP_VALID=%b, want 1 0", CHAR_RDY, OP_VALID);
    end
  endtask

  task automatic test_sub_ack();
    send("1"); send("5"); send(8'h0D); send("0"); send("9"); send(8'h0A); send("-");
    checks++;
    if (X !== 5'd15 || Y !== 5'd9 || C0 !== 1'b1 || OP_VALID !== 1'b1) begin
      errors++; $display("FAIL sub_result: X=%0d Y=%0d C0=%b OP_VALID=%b, want 15 9 1 1", X, Y, C0, OP_VALID);
    end
    ack();
    checks++;
    if (OP_VALID !== 1'b0 || CHAR_RDY !== 1'b1 || X !== 5'd15 || C0 !== 1'b1) begin
      errors++; $display("FAIL sub_ack: OP_VALID=%b RDY=%b X=%0d C0=%b, want 0 1 15 1", OP_VALID, CHAR_RDY, X, C0);
    end
  endtask

  task automatic test_range_error();
    send("1"); send("6"); send(8'h0A);
    checks++;
    if (ERR !== 1'b1 || X !== 5'd15 || CHAR_RDY !== 1'b1) begin
      errors++; $display("FAIL range_err: ERR=%b X=%0d RDY=%b, want 1 15 1", ERR, X, CHAR_RDY);
    end
    send("x");
    checks++;
    if (ERR !== 1'b1) begin
      errors++; $display("FAIL range_junk: ERR=%b want 1", ERR);
    end
    send(8'h0A);
    checks++;
    if (ERR !== 1'b0 || X !== 5'd15) begin
      errors++; $display("FAIL range_clear: ERR=%b X=%0d, want 0 15", ERR, X);
    end
    send("0"); send("1"); send(8'h0A);
    checks++;
    if (X !== 5'd1 || ERR !== 1'b0) begin
      errors++; $display("FAIL range_restart: X=%0d ERR=%b, want 1 0", X, ERR);
    end
    send("z"); send(8'h0D);
  endtask

  task automatic test_bad_op();
    send("0"); send("3"); send(8'h0A); send("0"); send("4"); send(8'h0A); send("*");
    checks++;
    if (ERR !== 1'b1 || OP_VALID !== 1'b0 || X !== 5'd3 || Y !== 5'd4) begin
      errors++; $display("FAIL bad_op: ERR=%b OP_VALID=%b X=%0d Y=%0d, want 1 0 3 4", ERR, OP_VALID, X, Y);
    end
    send(8'h0A);
    send("0"); send("6"); send(8'h0A); send("1"); send("1"); send(8'h0A); send("+");
    checks++;
    if (ERR !== 1'b0 || OP_VALID !== 1'b1 || X !== 5'd6 || Y !== 5'd11 || C0 !== 1'b0) begin
      errors++; $display("FAIL bad_op_recover: ERR=%b OP_VALID=%b X=%0d Y=%0d C0=%b, want 0 1 6 11 0", ERR, OP_VALID, X, Y, C0);
    end
  endtask

  task automatic test_done_ignore();
    send("9"); send(8'h0A); send("-");
    checks++;
    if (X !== 5'd6 || Y !== 5'd11 || C0 !== 1'b0 || OP_VALID !== 1'b1 || CHAR_RDY !== 1'b0) begin
      errors++; $display("FAIL done_ignore: X=%0d Y=%0d C0=%b OP_VALID=%b RDY=%b, want 6 11 0 1 0", X, Y, C0, OP_VALID, CHAR_RDY);
    end
`ifdef ECHO_EN
    checks++;
    if (ECHO_VALID !== 1'b0) begin
      errors++; $display("FAIL done_echo: ECHO_VALID=%b want 0", ECHO_VALID);
    end
`endif
    ack();
  endtask

  task automatic test_reset_mid();
    send("0"); send("5");
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (X !== 5'd0 || ERR !== 1'b0 || CHAR_RDY !== 1'b1 || OP_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_mid: X=%0d ERR=%b RDY=%b OP_VALID=%b, want 0 0 1 0", X, ERR, CHAR_RDY, OP_VALID);
    end
    send("0"); send("2"); send(8'h0A); send("0"); send("1"); send(8'h0A); send("+");
    checks++;
    if (X !== 5'd2 || Y !== 5'd1 || OP_VALID !== 1'b1) begin
      errors++; $display("FAIL reset_mid_seq: X=%0d Y=%0d OP_VALID=%b, want 2 1 1", X, Y, OP_VALID);
    end
    // Reset while DONE must drop the result.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (OP_VALID !== 1'b0 || CHAR_RDY !== 1'b1 || Y !== 5'd0) begin
      errors++; $display("FAIL reset_done: OP_VALID=%b RDY=%b Y=%0d, want 0 1 0", OP_VALID, CHAR_RDY, Y);
    end
  endtask

  task automatic test_back_to_back();
    send("0"); send("9"); send(8'h0A); send("1"); send("3"); send(8'h0D); send("-");
    ack();
    send("1");
`ifdef ECHO_EN
    checks++;
    if (ECHO_VALID !== 1'b1 || ECHO_CHAR !== 8'h31) begin
      errors++; $display("FAIL b2b_echo: ECHO_VALID=%b ECHO_CHAR=%h, want 1 31", ECHO_VALID, ECHO_CHAR);
    end
`endif
    checks++;
    if (X !== 5'd9 || Y !== 5'd13 || C0 !== 1'b1 || OP_VALID !== 1'b0) begin
      errors++; $display("FAIL b2b_first: X=%0d Y=%0d C0=%b OP_VALID=%b, want 9 13 1 0", X, Y, C0, OP_VALID);
    end
    send("0"); send(8'h0A); send("0"); send("0"); send(8'h0A); send("+");
    checks++;
    if (X !== 5'd10 || Y !== 5'd0 || C0 !== 1'b0 || OP_VALID !== 1'b1) begin
      errors++; $display("FAIL b2b_second: X=%0d Y=%0d C0=%b OP_VALID=%b, want 10 0 0 1", X, Y, C0, OP_VALID);
    end
    ack();
  endtask

  function automatic logic [7:0] good_byte(input int pos);
    case (pos)
      0, 3:    return ($urandom_range(0, 9) < 7) ? 8'(8'h30 + $urandom_range(0, 1)) : 8'(8'h30 + $urandom_range(2, 9));
      1, 4:    return 8'(8'h30 + $urandom_range(0, 9));
      2, 5:    return $urandom_range(0, 1) ? 8'h0A : 8'h0D;
      default: return $urandom_range(0, 1) ? 8'h2B : 8'h2D;
    endcase
  endfunction

  task automatic test_random();
    logic       v, a, r;
    logic [7:0] b;
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 299) == 0);
      a = m_done ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
      if (m_err)
        b = ($urandom_range(0, 1) != 0) ? 8'h0A : 8'($urandom_range(0, 255));
      else if (!m_done && $urandom_range(0, 99) < 88)
        b = good_byte(q.size());
      else
        b = 8'($urandom_range(0, 255));
      step(v, b, a, r);
      checks++;
      if (X !== m_x || Y !== m_y || C0 !== m_c0) begin
        errors++;
        $display("FAIL rand_data cycle %0d: X=%0d Y=%0d C0=%b, want %0d %0d %b", i, X, Y, C0, m_x, m_y, m_c0);
      end
      checks++;
      if (OP_VALID !== m_done || ERR !== m_err || CHAR_RDY !== !m_done) begin
        errors++;
        $display("FAIL rand_flags cycle %0d: OP_VALID=%b ERR=%b RDY=%b, want %b %b %b", i, OP_VALID, ERR, CHAR_RDY, m_done, m_err, !m_done);
      end
`ifdef ECHO_EN
      checks++;
      if (ECHO_VALID !== m_ev || (m_ev && ECHO_CHAR !== m_ec)) begin
        errors++;
        $display("FAIL rand_echo cycle %0d: ECHO_VALID=%b ECHO_CHAR=%h, want %b %h", i, ECHO_VALID, ECHO_CHAR, m_ev, m_ec);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_ack();
    test_range_error();
    test_bad_op();
    test_done_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_entry_fsm.md
Name: operand_entry_fsm

Overview:
Sequential front end for the 5-bit add/subtract datapath. It consumes an ASCII character stream one byte per handshake: two decimal digits plus Enter for X, the same for Y, then an operator character. It range-checks each operand and presents registered X, Y and C0 (0 = add, 1 = subtract) to the adder with a valid/ack handshake. Malformed input is flagged, discarded, and entry restarts cleanly.

Parameters:
WIDTH, 5, operand width of X and Y outputs
MAX_VAL, 15, largest legal operand value; must be < 2**WIDTH and <= 99

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous, active-high reset
CHAR_VALID  input  1  CHAR carries a byte this cycle
CHAR  input  8  ASCII byte
CHAR_RDY  output  1  block can accept a byte; a transfer occurs when CHAR_VALID && CHAR_RDY at a rising edge
X  output  WIDTH  operand X, registered
Y  output  WIDTH  operand Y, registered
C0  output  1  0 = add ('+'), 1 = subtract ('-')
OP_VALID  output  1  X/Y/C0 complete and stable
OP_ACK  input  1  consumer has taken the operands
ERR  output  1  malformed entry in progress

Behaviour:
- Interface: one clock CLK; RST synchronous active-high. All outputs registered.
- Reset values: X=0, Y=0, C0=0, OP_VALID=0, ERR=0, CHAR_RDY=1, state=X_TENS.
- States: X_TENS, X_ONES, X_ENT, Y_TENS, Y_ONES, Y_ENT, OP, DONE, ERROR.
- Byte classes: digit = 0x30..0x39; Enter = 0x0A or 0x0D; plus = 0x2B; minus = 0x2D.
- Transitions happen only on a transfer.
- *_TENS: on a digit, store the tens value and go to *_ONES. Any other byte goes to ERROR.
- *_ONES: on a digit, compute acc = tens*10 + ones (7-bit internal) and go to *_ENT. Any other byte goes to ERROR.
- *_ENT, on Enter with acc <= MAX_VAL:
  - load X (or Y) with acc[WIDTH-1:0].
  - go to Y_TENS (or OP).
- *_ENT, on Enter with acc > MAX_VAL, or on any non-Enter byte: go to ERROR. X/Y keep their previous values.
- OP: '+' sets C0=0 and goes to DONE. '-' sets C0=1 and goes to DONE. Any other byte goes to ERROR.
- OP_VALID rises the cycle after the operator transfer.
- DONE:
  - CHAR_RDY=0 and OP_VALID=1.
  - X, Y and C0 are frozen.
  - On OP_ACK=1: go to X_TENS; OP_VALID=0 and CHAR_RDY=1 from the next cycle.
  - OP_ACK outside DONE is ignored.
- ERROR:
  - ERR=1 and CHAR_RDY=1; bytes are consumed and discarded.
  - An Enter byte returns the FSM to X_TENS and clears ERR the next cycle.
  - OP_VALID stays 0.
- A CHAR_VALID byte while CHAR_RDY=0 is dropped; it is the producer's duty to hold the byte.
- RST mid-entry or in DONE: all state is discarded and reset values apply the next cycle; the partial operand is lost.
- Latency: from the operator transfer edge to OP_VALID=1 is 1 cycle.

Optional Feature:
ECHO_EN:
- Defined: adds outputs ECHO_VALID (1) and ECHO_CHAR (8). Every transferred byte, including those consumed in ERROR, is copied to ECHO_CHAR with ECHO_VALID high for exactly 1 cycle, 1 cycle after the transfer. Both outputs reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- "0","7",0x0A,"1","2",0x0A,"+" -> X=7, Y=12, C0=0; OP_VALID=1 one cycle after "+"; CHAR_RDY=0 until OP_ACK.
- "1","5",0x0D,"0","9",0x0A,"-" then OP_ACK pulse -> X=15, Y=9, C0=1; OP_VALID=0 and CHAR_RDY=1 the cycle after the ack.
- "1","6",0x0A -> ERR=1 (16 > MAX_VAL); then "x",0x0A -> ERR=0, state X_TENS; X retains its prior value.
- "0","3",0x0A,"0","4",0x0A,"*" -> ERR=1, OP_VALID stays 0; after 0x0A, a full valid sequence completes normally.
- RST asserted after "0","5" -> next cycle X=0, ERR=0, CHAR_RDY=1; "0","2",0x0A,"0","1",0x0A,"+" yields X=2, Y=1.
- Bytes driven with CHAR_VALID while in DONE -> ignored; X, Y and C0 are unchanged. With ECHO_EN, each accepted byte echoes once, 1 cycle after its transfer.
